inst_fetch_enq: RTL and testbench
=================================

// Module: inst_fetch_enq
// PURPOSE
//  Fetch stage that feeds the instruction queue (sync_fifo, DATA_WIDTH=64).
//  Issues one 32-bit imem read per instruction, one request outstanding at a time.
//  Packs each returned word with its PC and enqueues {pc, inst} into the queue.
//  Accepts backend redirects; in-flight responses fetched on the stale path are discarded.
// PARAMETERS
//  RESET_PC    32'h1eceb000  PC fetched first after reset
//  DATA_WIDTH  64            queue entry width; must equal 64 ({pc[31:0], inst[31:0]})
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset, synchronous, active-high
//  redirect_valid in   1   1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc    in   32  new fetch PC; bits [1:0] ignored (forced 0)
//  imem_addr      out  32  request address, valid while imem_rmask!=0
//  imem_rmask     out  4   4'hf for exactly one cycle per request, else 4'h0
//  imem_rdata     in   32  response data, valid while imem_resp=1
//  imem_resp      in   1   1-cycle response strobe
//  enqueue        out  1   push to instruction queue
//  wdata          out  64  {pc_of_inst, inst}
//  is_full        in   1   queue full flag
//  perf_stall_cnt out  32  cycles in FETCH blocked by is_full (see CONFIGURATION)
//  perf_drop_cnt  out  32  imem responses discarded by redirect
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, imem_rmask=0, enqueue=0, wdata=0, perf counters=0.
//  Combinational outputs: imem_rmask, imem_addr=pc, enqueue, wdata. Registered: pc, state, counters.
//  States: FETCH, WAIT, DISCARD.
//   FETCH: if redirect_valid -> pc<=redirect_pc&~3, no request, stay in FETCH.
//          elif is_full -> no request, stay; stall counter +1.
//          else imem_rmask=4'hf, imem_addr=pc -> WAIT.
//   WAIT:  resp & !redirect -> enqueue=1, wdata={pc,imem_rdata}; pc<=pc+4; -> FETCH.
//          resp & redirect  -> no enqueue; pc<=redirect_pc; drop counter +1; -> FETCH.
//          !resp & redirect -> pc<=redirect_pc; -> DISCARD.
//          else stay.
//   DISCARD: resp -> drop counter +1, -> FETCH; redirect (any cycle) -> pc<=redirect_pc (last wins).
//  imem_resp in FETCH is ignored (stale response after reset).
//  No-overflow: only this block writes the queue; a request issues only when !is_full,
//   and one request is outstanding, so the enqueue slot is guaranteed. enqueue is never
//   asserted while is_full=1.
//  Throughput: min 2 cycles/instruction (FETCH, WAIT with same-cycle resp).
//  pc+4 wraps modulo 2^32. Redirect does not flush the queue (owned by backend).
//  Reset mid-WAIT/DISCARD: returns to FETCH at RESET_PC; late resp ignored.
// CONFIGURATION
//  INST_FETCH_PERF_EN defined: perf_stall_cnt/perf_drop_cnt count as above, saturating
//   at 32'hffffffff, cleared by rst.
//  Not defined: counters not instantiated; both ports tied to 32'h0; function unchanged.
// TESTING
//  1 Reset, imem 0-latency resp 32'h00000013 -> enqueue wdata=64'h1eceb000_00000013; next imem_addr=32'h1eceb004.
//  2 is_full=1 for 10 cycles in FETCH -> imem_rmask=0 throughout, perf_stall_cnt=10 (PERF_EN);
//    release -> request at unchanged pc next cycle.
//  3 Redirect to 32'h1eceb103 in WAIT, resp 3 cycles later -> no enqueue, perf_drop_cnt=1;
//    next imem_addr=32'h1eceb100.
//  4 Redirect same cycle as resp -> no enqueue; next request addr=redirect_pc.
//  5 rst asserted in WAIT, resp arrives 1 cycle after rst drop -> ignored; first request addr=RESET_PC.
//  6 Stream 64 insts with random imem latency 0-5 and random is_full -> queue contents match
//    sequential pc from RESET_PC; enqueue never with is_full=1.

Source files
------------

// File: rtl/inst_fetch_enq_if.sv
// Fetch-stage bus bundle: imem request/response, redirect input, queue push and perf counters.
// The fetch block is the master; the imem/queue/backend side is the slave.
interface inst_fetch_enq_if #(
    parameter int DATA_WIDTH = 64
);
    // Handshakes: a request is valid in any cycle where imem_rmask != 0 and it has no ready;
    // imem_resp is a one-cycle strobe qualifying imem_rdata; enqueue is a one-cycle push that
    // the queue always accepts, because the master pushes only into a slot it checked was free;
    // redirect_valid is a one-cycle strobe qualifying redirect_pc.
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic [31:0]           imem_addr;
    logic [3:0]            imem_rmask;
    logic [31:0]           imem_rdata;
    logic                  imem_resp;
    logic                  enqueue;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  is_full;
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_drop_cnt;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, imem_resp, is_full,
        output imem_addr, imem_rmask, enqueue, wdata, perf_stall_cnt, perf_drop_cnt
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, imem_resp, is_full,
        input  imem_addr, imem_rmask, enqueue, wdata, perf_stall_cnt, perf_drop_cnt
    );
endinterface

// File: rtl/inst_fetch_enq.sv
// Fetch stage: one imem read outstanding, pushes {pc, inst} into the instruction queue.
// Optional perf counters are enabled by defining INST_FETCH_PERF_EN.
module inst_fetch_enq #(
    parameter logic [31:0] RESET_PC   = 32'h1eceb000,
    parameter int          DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_fetch_enq_if.master        io_bus,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("inst_fetch_enq: DATA_WIDTH must be 64");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_pc;
    logic [31:0]           w_pc_nxt;
    logic [31:0]           w_redir_pc;
    logic [3:0]            w_rmask;
    logic                  w_enq;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_stall_inc;
    logic                  w_drop_inc;

    assign w_redir_pc = {io_bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_rmask     = 4'h0;
        w_enq       = 1'b0;
        w_wdata     = '0;
        w_stall_inc = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            S_FETCH: begin
                // imem_resp here can only be a leftover from before reset; ignore it.
                if (io_bus.redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end else if (io_bus.is_full) begin
                    w_stall_inc = 1'b1;
                end else begin
                    w_rmask     = 4'hf;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_bus.imem_resp) begin
                    if (io_bus.redirect_valid) begin
                        w_pc_nxt   = w_redir_pc;
                        w_drop_inc = 1'b1;
                    end else begin
                        w_enq    = 1'b1;
                        w_wdata  = {r_pc, io_bus.imem_rdata};
                        w_pc_nxt = r_pc + 32'd4;
                    end
                    w_state_nxt = S_FETCH;
                end else if (io_bus.redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // Stale-path response still owed; the latest redirect target wins.
                if (io_bus.redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end
                if (io_bus.imem_resp) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
        if (rst) begin
            w_rmask = 4'h0;
            w_enq   = 1'b0;
            w_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign io_bus.imem_addr  = r_pc;
    assign io_bus.imem_rmask = w_rmask;
    assign io_bus.enqueue    = w_enq;
    assign io_bus.wdata      = w_wdata;
    assign o_dbg_state       = r_state;

`ifdef INST_FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_drop_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'h0;
            r_drop_cnt  <= 32'h0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != 32'hffffffff)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_drop_inc && (r_drop_cnt != 32'hffffffff)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign io_bus.perf_stall_cnt = r_stall_cnt;
    assign io_bus.perf_drop_cnt  = r_drop_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf         = w_stall_inc ^ w_drop_inc;
    assign io_bus.perf_stall_cnt = 32'h0;
    assign io_bus.perf_drop_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_enq.sv
// Directed bench for inst_fetch_enq: reset, stall, redirect, reset-in-flight, wrap and a stream.
module tb_inst_fetch_enq;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;
`ifdef INST_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    inst_fetch_enq_if #(.DATA_WIDTH(64)) bus ();

    inst_fetch_enq #(
        .RESET_PC   (RESET_PC),
        .DATA_WIDTH (64)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.enqueue === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("enq_unexpected", 64'(bus.wdata), 64'h0);
            end else begin
                check("enq_wdata", 64'(bus.wdata), exp_q.pop_front());
                check("enq_while_full", 64'(bus.is_full), 64'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Entered in FETCH with is_full=0; leaves in FETCH at exp_pc+4.
    task automatic do_fetch(input logic [31:0] exp_pc, input int lat, input logic [31:0] inst);
        settle();
        check("req_rmask", 64'(bus.imem_rmask), 64'hf);
        check("req_addr", 64'(bus.imem_addr), 64'(exp_pc));
        cyc();
        repeat (lat) begin
            bus.imem_resp = 1'b0;
            settle();
            check("wait_rmask", 64'(bus.imem_rmask), 64'h0);
            cyc();
        end
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = inst;
        exp_q.push_back({exp_pc, inst});
        settle();
        cyc();
        bus.imem_resp = 1'b0;
        settle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rdata     = 32'h0;
        bus.imem_resp      = 1'b0;
        bus.is_full        = 1'b0;
        cyc();
        cyc();
        settle();
        check("rst_rmask", 64'(bus.imem_rmask), 64'h0);
        check("rst_enqueue", 64'(bus.enqueue), 64'h0);
        check("rst_wdata", 64'(bus.wdata), 64'h0);
        check("rst_stall_cnt", 64'(bus.perf_stall_cnt), 64'h0);
        check("rst_drop_cnt", 64'(bus.perf_drop_cnt), 64'h0);

        // 1: zero-latency response
        rst = 1'b0;
        do_fetch(32'h1eceb000, 0, 32'h00000013);
        settle();
        check("t1_next_addr", 64'(bus.imem_addr), 64'h1eceb004);

        // 2: queue full for 10 FETCH cycles
        for (int i = 0; i < 10; i++) begin
            bus.is_full = 1'b1;
            settle();
            check("t2_full_rmask", 64'(bus.imem_rmask), 64'h0);
            cyc();
        end
        bus.is_full = 1'b0;
        settle();
        check("t2_stall_cnt", 64'(bus.perf_stall_cnt), PERF ? 64'd10 : 64'd0);
        check("t2_release_rmask", 64'(bus.imem_rmask), 64'hf);
        check("t2_release_addr", 64'(bus.imem_addr), 64'h1eceb004);
        do_fetch(32'h1eceb004, 1, 32'h00100093);

        // 3: redirect in WAIT, response 3 cycles later is dropped
        settle();
        check("t3_req_addr", 64'(bus.imem_addr), 64'h1eceb008);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1eceb103;
        settle();
        check("t3_redir_enqueue", 64'(bus.enqueue), 64'h0);
        cyc();
        bus.redirect_valid = 1'b0;
        cyc();
        cyc();
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'hbad0bad0;
        settle();
        check("t3_drop_enqueue", 64'(bus.enqueue), 64'h0);
        check("t3_drop_rmask", 64'(bus.imem_rmask), 64'h0);
        cyc();
        bus.imem_resp = 1'b0;
        settle();
        check("t3_drop_cnt", 64'(bus.perf_drop_cnt), PERF ? 64'd1 : 64'd0);
        check("t3_next_rmask", 64'(bus.imem_rmask), 64'hf);
        check("t3_next_addr", 64'(bus.imem_addr), 64'h1eceb100);

        // 4: redirect in the same cycle as the response
        cyc();
        bus.imem_resp      = 1'b1;
        bus.imem_rdata     = 32'hbad1bad1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00002001;
        settle();
        check("t4_enqueue", 64'(bus.enqueue), 64'h0);
        cyc();
        bus.imem_resp      = 1'b0;
        bus.redirect_valid = 1'b0;
        settle();
        check("t4_next_addr", 64'(bus.imem_addr), 64'h00002000);
        check("t4_drop_cnt", 64'(bus.perf_drop_cnt), PERF ? 64'd2 : 64'd0);
        do_fetch(32'h00002000, 2, 32'hdeadbeef);

        // 7: redirect in FETCH to the top of memory, pc+4 wraps to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hfffffffe;
        settle();
        check("t7_redir_rmask", 64'(bus.imem_rmask), 64'h0);
        cyc();
        bus.redirect_valid = 1'b0;
        do_fetch(32'hfffffffc, 0, 32'h00000073);
        do_fetch(32'h00000000, 3, 32'h11111111);

        // 5: reset while WAIT, stale response right after reset drops
        settle();
        check("t5_req_addr", 64'(bus.imem_addr), 64'h00000004);
        cyc();
        rst = 1'b1;
        settle();
        check("t5_rst_rmask", 64'(bus.imem_rmask), 64'h0);
        check("t5_rst_enqueue", 64'(bus.enqueue), 64'h0);
        cyc();
        rst            = 1'b0;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 32'hbad2bad2;
        settle();
        check("t5_stale_enqueue", 64'(bus.enqueue), 64'h0);
        check("t5_stall_cleared", 64'(bus.perf_stall_cnt), 64'h0);
        check("t5_drop_cleared", 64'(bus.perf_drop_cnt), 64'h0);
        do_fetch(RESET_PC, 0, 32'h00200113);

        // 6: 64-instruction stream with random latency and queue-full gaps
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pc  = RESET_PC;
        for (int k = 0; k < 64; k++) begin
            int n_full;
            n_full = $urandom_range(0, 2);
            for (int j = 0; j < n_full; j++) begin
                bus.is_full = 1'b1;
                settle();
                check("t6_full_rmask", 64'(bus.imem_rmask), 64'h0);
                cyc();
            end
            bus.is_full = 1'b0;
            do_fetch(pc, $urandom_range(0, 5), $urandom());
            pc = pc + 32'd4;
        end
        cyc();
        cyc();
        check("exp_q_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
